// File: rtl/aliens_io_regs.sv
// Aliens I/O register window: player/DIP reads, control latch, sound command latch with
// held IRQ, and watchdog. Define WATCHDOG_EN to build the watchdog counter.
module aliens_io_regs #(
   parameter int unsigned WDT_CYCLES = 1200000,
   parameter int unsigned WDT_PULSE  = 16
) (
   input  logic       CLK12,
   input  logic       RSTn,
   input  logic       IOCS,
   input  logic       RWb,
   input  logic [4:0] ADDR,
   input  logic [7:0] DIN,
   output logic [7:0] DOUT,
   output logic       DOE,
   input  logic [7:0] P1,
   input  logic [7:0] P2,
   input  logic [7:0] DSW1,
   input  logic [7:0] DSW2,
   input  logic [7:0] DSW3,
   input  logic       SND_ACK,
   output logic       COIN1,
   output logic       COIN2,
   output logic       RMRD,
   output logic       INIT,
   output logic [7:0] SND_LATCH,
   output logic       SND_IRQ,
   output logic       WDT_RSTn
);

   logic       rd, wr;
   logic       wr_q, wr_prev;
   logic [4:0] addr_q;
   logic [7:0] din_q;
   logic [7:0] rd_data;
   logic       commit, commit_ctrl, commit_snd;
   logic       ack_s1, ack_s2, ack_d, ack_edge;

   assign rd = ~IOCS & RWb;
   assign wr = ~IOCS & ~RWb;

   always_comb begin
      rd_data = 8'hFF;
      case (ADDR)
         5'h00:   rd_data = DSW3;
         5'h01:   rd_data = P1;
         5'h02:   rd_data = P2;
         5'h03:   rd_data = DSW2;
         5'h04:   rd_data = DSW1;
         default: rd_data = 8'hFF;
      endcase
   end

   // DOE is the registered read qualifier itself; DOUT only moves on a read.
   always_ff @(posedge CLK12 or negedge RSTn) begin
      if (!RSTn) begin
         wr_q    <= 1'b0;
         wr_prev <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         DOE     <= 1'b0;
         DOUT    <= '1;
      end else begin
         wr_q    <= wr;
         wr_prev <= wr_q;
         addr_q  <= ADDR;
         din_q   <= DIN;
         DOE     <= rd;
         if (rd) DOUT <= rd_data;
      end
   end

   assign commit      = wr_q & ~wr_prev;
   assign commit_ctrl = commit && (addr_q == 5'h08);
   assign commit_snd  = commit && (addr_q == 5'h0C);

   always_ff @(posedge CLK12 or negedge RSTn) begin
      if (!RSTn) begin
         COIN1 <= 1'b0;
         COIN2 <= 1'b0;
         RMRD  <= 1'b0;
         INIT  <= 1'b0;
      end else if (commit_ctrl) begin
         COIN1 <= din_q[0];
         COIN2 <= din_q[1];
         RMRD  <= din_q[5];
         INIT  <= din_q[6];
      end
   end

   always_ff @(posedge CLK12 or negedge RSTn) begin
      if (!RSTn) begin
         ack_s1 <= 1'b0;
         ack_s2 <= 1'b0;
         ack_d  <= 1'b0;
      end else begin
         ack_s1 <= SND_ACK;
         ack_s2 <= ack_s1;
         ack_d  <= ack_s2;
      end
   end

   assign ack_edge = ack_s2 & ~ack_d;

   // A latch write landing on the ack edge must keep the IRQ raised.
   always_ff @(posedge CLK12 or negedge RSTn) begin
      if (!RSTn) begin
         SND_LATCH <= '0;
         SND_IRQ   <= 1'b0;
      end else if (commit_snd) begin
         SND_LATCH <= din_q;
         SND_IRQ   <= 1'b1;
      end else if (ack_edge) begin
         SND_IRQ   <= 1'b0;
      end
   end

`ifdef WATCHDOG_EN
   localparam int unsigned CW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
   localparam int unsigned PW = $clog2(WDT_PULSE + 1);

   typedef enum logic {WD_COUNT, WD_PULSE} wd_state_t;

   wd_state_t      wd_state;
   logic [CW-1:0]  wd_cnt;
   logic [PW-1:0]  wd_pcnt;

   // Control writes are ignored while pulsing so the pulse always runs full length.
   always_ff @(posedge CLK12 or negedge RSTn) begin
      if (!RSTn) begin
         wd_state <= WD_COUNT;
         wd_cnt   <= '0;
         wd_pcnt  <= '0;
         WDT_RSTn <= 1'b1;
      end else begin
         case (wd_state)
            WD_COUNT: begin
               if (commit_ctrl) begin
                  wd_cnt <= '0;
               end else if (wd_cnt == CW'(WDT_CYCLES - 1)) begin
                  wd_state <= WD_PULSE;
                  wd_pcnt  <= '0;
                  WDT_RSTn <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt + CW'(1);
               end
            end
            WD_PULSE: begin
               if (wd_pcnt == PW'(WDT_PULSE - 1)) begin
                  wd_state <= WD_COUNT;
                  wd_cnt   <= '0;
                  WDT_RSTn <= 1'b1;
               end else begin
                  wd_pcnt <= wd_pcnt + PW'(1);
               end
            end
         endcase
      end
   end
`else
   assign WDT_RSTn = 1'b1;
`endif

endmodule

// File: doc/aliens_io_regs.md
# aliens_io_regs

CPU-side I/O register block for the Aliens board, sitting directly downstream of the bus-control decoder and consuming its active-low IOCS select for the 0x5F80–0x5F9F window. It returns player-input and DIP-switch bytes on reads. It latches the control register that drives RMRD and INIT back into bus control and the video chips. It also runs the sound-command latch with a held sound IRQ, and the watchdog.

## Interface
Parameters:
- WDT_CYCLES, 1200000: CLK12 cycles without a control-register write before the watchdog fires (100 ms at 12 MHz).
- WDT_PULSE, 16: length of the watchdog reset pulse, in cycles.

Ports:
- CLK12  in  1  system clock; all state updates on its rising edge.
- RSTn  in  1  asynchronous active-low reset.
- IOCS  in  1  active-low I/O select from bus control.
- RWb  in  1  CPU read/not-write; 1 = read.
- ADDR  in  5  CPU address bits [4:0].
- DIN  in  8  CPU write data.
- DOUT  out  8  CPU read data.
- DOE  out  1  read-data enable toward the CPU data bus.
- P1, P2  in  8 each  player inputs, active low, passed through unmodified.
- DSW1, DSW2, DSW3  in  8 each  DIP switch banks.
- SND_ACK  in  1  sound-CPU acknowledge; asynchronous.
- COIN1, COIN2  out  1 each  coin counter drives.
- RMRD  out  1  tile ROM read-mode select, fed to bus control.
- INIT  out  1  palette/work-RAM bank select, fed to bus control.
- SND_LATCH  out  8  sound command byte.
- SND_IRQ  out  1  sound CPU interrupt request, active high.
- WDT_RSTn  out  1  watchdog reset request, active low.

## Operation
- Access qualifier: rd = !IOCS & RWb; wr = !IOCS & !RWb. Both are registered each cycle.
- Write commit:
  - A write commits exactly once, on the first cycle a registered wr is seen after a cycle without it.
  - A held or stretched write never commits twice.
- Write map, decoded on ADDR[4:0]:
  - 0x08, control register. COIN1 = DIN[0], COIN2 = DIN[1], RMRD = DIN[5], INIT = DIN[6]. Other bits are ignored. The write also restarts the watchdog.
  - 0x0C, sound latch. SND_LATCH = DIN. SND_IRQ is set.
  - All other offsets: the write is ignored.
- Read map: 0x00 DSW3, 0x01 P1, 0x02 P2, 0x03 DSW2, 0x04 DSW1. All other offsets return 0xFF.
- Sound handshake:
  - SND_ACK passes through a 2-flop synchronizer.
  - A rising edge on the synchronized signal clears SND_IRQ.
  - If a latch write commits in the same cycle as the ack edge, the write wins and SND_IRQ stays 1.
- Watchdog counter:
  - Counts up from 0 each cycle.
  - Returns to 0 on any committed 0x08 write.
  - On reaching WDT_CYCLES-1, drives WDT_RSTn low for WDT_PULSE cycles, then returns to 0 and resumes counting.
  - A 0x08 write during the pulse does not shorten the pulse.

## Timing
- Reset values: DOUT=0xFF, DOE=0, COIN1=COIN2=0, RMRD=0, INIT=0, SND_LATCH=0x00, SND_IRQ=0, WDT_RSTn=1, watchdog counter=0, synchronizer flops=0.
- Write latency: outputs update 2 cycles after the first CLK12 edge that samples wr. That is one cycle for the wr register and one for the commit.
- Read latency:
  - DOUT and DOE are valid 1 cycle after the edge that samples rd.
  - DOE falls 1 cycle after IOCS deasserts.
  - DOUT holds its last value while DOE=0.
- SND_IRQ clear latency: 3 cycles after SND_ACK rises (2 synchronizer cycles plus 1 edge-detect cycle).
- An ack arriving while SND_IRQ=0 has no effect.
- Watchdog counter width is ceil(log2(WDT_CYCLES)). The counter must not wrap before the terminal compare.
- Reset mid-operation:
  - RSTn low forces all reset values immediately.
  - A pending commit is dropped.
  - An active watchdog pulse is terminated.

## Configuration
- WATCHDOG_EN defined: watchdog counter and pulse behave as specified.
- WATCHDOG_EN undefined:
  - No counter is built.
  - WDT_RSTn is tied to 1.
  - 0x08 writes only update the control bits.

## Test plan
- Reset release, then read 0x01 with P1=0xA5 → DOUT=0xA5 with DOE=1 one cycle after rd is sampled. Read 0x07 → 0xFF.
- Write 0x08 with DIN=0x63, IOCS held low 4 cycles → COIN1=1, COIN2=1, RMRD=1, INIT=1 two cycles after the first sample. Exactly one commit occurs.
- Write 0x0C with DIN=0x3C → SND_LATCH=0x3C and SND_IRQ=1. Pulse SND_ACK → SND_IRQ=0 three cycles after the ack rises.
- Latch write 0x0C committing in the same cycle as the synchronized ack edge → SND_IRQ remains 1 and SND_LATCH holds the new byte.
- WATCHDOG_EN with WDT_CYCLES=100 and no writes → WDT_RSTn low for exactly 16 cycles starting at cycle 100, then repeats. With a 0x08 write every 50 cycles, WDT_RSTn never falls.
- Assert RSTn low during SND_IRQ=1 and an active watchdog pulse → all outputs return to reset values asynchronously.
